// File: rtl/sram_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
//  Package : sram_pkg
//  Shared types and constants for the byte-wide SRAM FIFO controller.
//  Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package sram_pkg;

   localparam int ADDR_W     = 7;
   localparam int DATA_W     = 8;
   localparam int SRAM_DEPTH = 128;

   // Controller sequencing: one SRAM op per WRITE/READ cycle, CAPTURE
   // is the cycle in which the SRAM read data is presented.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      READ    = 2'd2,
      CAPTURE = 2'd3
   } fifo_state_t;

   // Kind of the most recently issued SRAM operation.
   typedef enum logic {
      WR = 1'b0,
      RD = 1'b1
   } op_t;

endpackage : sram_pkg
`default_nettype wire

// File: rtl/byte_sram_fifo_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
//  Module  : byte_sram_fifo_ctrl
//  FIFO controller in front of a single-port byte SRAM. Writes and reads
//  share the one SRAM port; a one-entry output register holds the head
//  byte for the consumer.
//  Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module byte_sram_fifo_ctrl
   import sram_pkg::*;
#(
   parameter int DEPTH = SRAM_DEPTH,
   parameter int DW    = DATA_W
)(
   input  logic                         sram_clk,
   input  logic                         sram_ares,
   input  logic                         push_valid,
   input  logic [DW-1:0]                push_data,
   output logic                         push_ready,
   output logic                         pop_valid,
   output logic [DW-1:0]                pop_data,
   input  logic                         pop_ready,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full,
   output logic                         empty,
   output logic                         wr_enable,
   output logic                         rd_enable,
   output logic [$clog2(DEPTH)-1:0]     ram_index,
   output logic [DW-1:0]                sram_data_in,
   input  logic [DW-1:0]                sram_data_out
);

   localparam int                AW       = $clog2(DEPTH);
   localparam int                CNT_W    = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0]  FULL_LVL = CNT_W'(DEPTH);

   // FSM and strobe registers
   fifo_state_t       state_q, state_d;
   logic              wr_enable_q, wr_enable_d;
   logic              rd_enable_q, rd_enable_d;

   // Datapath registers
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [DW-1:0]     out_data_q, out_data_d;
   op_t               last_op_q, last_op_d;
   logic [AW-1:0]     ram_index_q, ram_index_d;
   logic [DW-1:0]     sram_data_in_q, sram_data_in_d;

   // Decoded status
   logic              w_in_write;
   logic              w_rd_busy;
   logic              w_rd_eligible;
   logic              w_push_ready;
   logic              w_push_hs;
   logic              w_pop_hs;
   logic              w_rd_issue;
   logic [CNT_W-1:0]  w_level;

   // Occupancy counts every byte the controller owns: stored in SRAM,
   // being written, being read back, or waiting in the output register.
   assign w_in_write    = (state_q == WRITE);
   assign w_rd_busy     = (state_q == READ) || (state_q == CAPTURE);
   assign w_level       = mem_cnt_q + CNT_W'(w_in_write) + CNT_W'(w_rd_busy)
                          + CNT_W'(out_valid_q);
   assign w_rd_eligible = (mem_cnt_q != '0) && !out_valid_q && !w_rd_busy;
   // A pending read that lost the last arbitration round wins this one.
   assign w_push_ready  = !sram_ares && (w_level < FULL_LVL) && (state_q != READ)
                          && !(w_rd_eligible && (last_op_q == WR));
   assign w_push_hs     = push_valid && w_push_ready;
   assign w_pop_hs      = out_valid_q && pop_ready;
   assign w_rd_issue    = w_rd_eligible && !w_push_hs;

   // State register and registered SRAM strobes
   always_ff @(posedge sram_clk) begin
      if (sram_ares) begin
         state_q     <= IDLE;
         wr_enable_q <= 1'b0;
         rd_enable_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_enable_q <= wr_enable_d;
         rd_enable_q <= rd_enable_d;
      end
   end

   // Next-state: a push takes the port, a READ always settles in CAPTURE
   always_comb begin
      state_d = IDLE;
      if (state_q == READ) begin
         state_d = CAPTURE;
      end else if (w_push_hs) begin
         state_d = WRITE;
      end else if (w_rd_eligible) begin
         state_d = READ;
      end else begin
         state_d = IDLE;
      end
   end

   // Strobe decode from the next state so the strobes leave a flop
   always_comb begin
      wr_enable_d = 1'b0;
      rd_enable_d = 1'b0;
      case (state_d)
         WRITE:   wr_enable_d = 1'b1;
         READ:    rd_enable_d = 1'b1;
         default: begin
            wr_enable_d = 1'b0;
            rd_enable_d = 1'b0;
         end
      endcase
   end

   // Datapath next values: pointers, SRAM address/data, count, output reg
   always_comb begin
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      last_op_d      = last_op_q;
      ram_index_d    = ram_index_q;
      sram_data_in_d = sram_data_in_q;
      out_valid_d    = out_valid_q;
      out_data_d     = out_data_q;
      // A finished write and a newly issued read can coincide and cancel.
      mem_cnt_d      = mem_cnt_q + CNT_W'(w_in_write) - CNT_W'(w_rd_issue);

      if (w_push_hs) begin
         ram_index_d    = wr_ptr_q;
         sram_data_in_d = push_data;
         wr_ptr_d       = wr_ptr_q + 1'b1;
         last_op_d      = WR;
      end else if (w_rd_issue) begin
         ram_index_d    = rd_ptr_q;
         rd_ptr_d       = rd_ptr_q + 1'b1;
         last_op_d      = RD;
      end

      // Reads are only issued with the output register empty, so the
      // capture and a pop never collide.
      if (state_q == CAPTURE) begin
         out_valid_d = 1'b1;
         out_data_d  = sram_data_out;
      end else if (w_pop_hs) begin
         out_valid_d = 1'b0;
      end
   end

   // Datapath registers; reset abandons any in-flight SRAM operation
   always_ff @(posedge sram_clk) begin
      if (sram_ares) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         mem_cnt_q      <= '0;
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
         last_op_q      <= RD;
         ram_index_q    <= '0;
         sram_data_in_q <= '0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         mem_cnt_q      <= mem_cnt_d;
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
         last_op_q      <= last_op_d;
         ram_index_q    <= ram_index_d;
         sram_data_in_q <= sram_data_in_d;
      end
   end

   assign push_ready   = w_push_ready;
   assign pop_valid    = out_valid_q;
   assign pop_data     = out_data_q;
   assign level        = w_level;
   assign full         = (w_level == FULL_LVL);
   assign empty        = (w_level == '0);
   assign wr_enable    = wr_enable_q;
   assign rd_enable    = rd_enable_q;
   assign ram_index    = ram_index_q;
   assign sram_data_in = sram_data_in_q;

endmodule : byte_sram_fifo_ctrl
`default_nettype wire

// File: tb/tb_byte_sram_fifo_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
//  Module  : tb_byte_sram_fifo_ctrl
//  Self-checking bench: a byte SRAM model beside the controller and a
//  queue-based FIFO reference that tracks accepted pushes and pops.
//  Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_byte_sram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       sram_ares = 1'b1;
   logic       push_valid = 1'b0;
   logic [7:0] push_data = 8'h00;
   logic       push_ready;
   logic       pop_valid;
   logic [7:0] pop_data;
   logic       pop_ready = 1'b0;
   logic [7:0] level;
   logic       full, empty;
   logic       wr_enable, rd_enable;
   logic [6:0] ram_index;
   logic [7:0] sram_data_in;
   logic [7:0] sram_data_out = 8'h00;

   always #5 clk = ~clk;

   byte_sram_fifo_ctrl dut (
      .sram_clk      (clk),
      .sram_ares     (sram_ares),
      .push_valid    (push_valid),
      .push_data     (push_data),
      .push_ready    (push_ready),
      .pop_valid     (pop_valid),
      .pop_data      (pop_data),
      .pop_ready     (pop_ready),
      .level         (level),
      .full          (full),
      .empty         (empty),
      .wr_enable     (wr_enable),
      .rd_enable     (rd_enable),
      .ram_index     (ram_index),
      .sram_data_in  (sram_data_in),
      .sram_data_out (sram_data_out)
   );

   // Byte SRAM: read data appears in the cycle after a read, else 0
   logic [7:0] mem [0:127];
   always @(posedge clk) begin
      if (wr_enable && !rd_enable) mem[ram_index] <= sram_data_in;
      if (rd_enable && !wr_enable) sram_data_out <= mem[ram_index];
      else                         sram_data_out <= 8'h00;
   end

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] q[$];
   logic       push_hs_s, pop_hs_s, rst_s;
   logic [7:0] pd_s;
   int         wr_cycles, rd_cycles;

   // One clock: sample handshakes mid-cycle, update the reference at the
   // edge, then compare the registered outputs just after it.
   task automatic tick();
      @(negedge clk);
      push_hs_s = push_valid && push_ready;
      pop_hs_s  = pop_valid && pop_ready;
      rst_s     = sram_ares;
      pd_s      = push_data;
      n_checks++;
      if (rst_s && push_ready !== 1'b0) begin
         n_fail++; $display("FAIL push_ready_in_reset: got %b expected 0", push_ready);
      end
      n_checks++;
      if (q.size() == 128 && push_ready !== 1'b0) begin
         n_fail++; $display("FAIL push_ready_when_full: got %b expected 0", push_ready);
      end
      if (pop_hs_s && !rst_s) begin
         n_checks++;
         if (q.size() == 0) begin
            n_fail++; $display("FAIL pop_underflow: got pop of %h with model empty", pop_data);
         end else if (pop_data !== q[0]) begin
            n_fail++; $display("FAIL pop_data: got %h expected %h", pop_data, q[0]);
         end
      end
      @(posedge clk);
      if (rst_s) q.delete();
      else begin
         if (pop_hs_s && q.size() > 0) void'(q.pop_front());
         if (push_hs_s) q.push_back(pd_s);
      end
      #1;
      if (wr_enable === 1'b1) wr_cycles++;
      if (rd_enable === 1'b1) rd_cycles++;
      n_checks++;
      if (int'(level) != q.size() || $isunknown(level)) begin
         n_fail++; $display("FAIL level: got %0d expected %0d", level, q.size());
      end
      n_checks++;
      if (full !== (q.size() == 128) || empty !== (q.size() == 0)) begin
         n_fail++; $display("FAIL full_empty: got full=%b empty=%b expected full=%b empty=%b",
                            full, empty, q.size() == 128, q.size() == 0);
      end
      n_checks++;
      if (wr_enable === 1'b1 && rd_enable === 1'b1) begin
         n_fail++; $display("FAIL strobes_exclusive: got wr=1 rd=1 expected not both");
      end
      n_checks++;
      if (pop_valid === 1'b1 && q.size() == 0) begin
         n_fail++; $display("FAIL pop_valid_empty: got 1 expected 0");
      end
   endtask

   task automatic do_reset();
      sram_ares  = 1'b1;
      push_valid = 1'b0;
      pop_ready  = 1'b0;
      tick();
      tick();
      sram_ares  = 1'b0;
      #1;
   endtask

   task automatic push_byte(input logic [7:0] d);
      int k;
      push_valid = 1'b1;
      push_data  = d;
      k = 0;
      do begin
         tick();
         k++;
      end while (!push_hs_s && k < 40);
      push_valid = 1'b0;
      n_checks++;
      if (!push_hs_s) begin
         n_fail++; $display("FAIL push_timeout: got no handshake expected accept of %h", d);
      end
   endtask

   task automatic drain();
      int k;
      push_valid = 1'b0;
      pop_ready  = 1'b1;
      k = 0;
      while (q.size() > 0 && k < 2000) begin
         tick();
         k++;
      end
      n_checks++;
      if (q.size() != 0 || empty !== 1'b1) begin
         n_fail++; $display("FAIL drain: got %0d left empty=%b expected 0 left empty=1", q.size(), empty);
      end
      pop_ready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (level !== 8'd0 || empty !== 1'b1 || full !== 1'b0 || pop_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_status: got level=%0d empty=%b full=%b pop_valid=%b expected 0 1 0 0",
                            level, empty, full, pop_valid);
      end
      n_checks++;
      if (wr_enable !== 1'b0 || rd_enable !== 1'b0 || ram_index !== 7'd0 || sram_data_in !== 8'd0) begin
         n_fail++; $display("FAIL reset_sram_port: got wr=%b rd=%b idx=%h din=%h expected all 0",
                            wr_enable, rd_enable, ram_index, sram_data_in);
      end
      n_checks++;
      if (push_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_push_ready: got %b expected 1", push_ready);
      end
   endtask

   task automatic test_single();
      int first_valid;
      do_reset();
      pop_ready  = 1'b1;
      push_valid = 1'b1;
      push_data  = 8'hA5;
      tick();
      push_valid = 1'b0;
      n_checks++;
      if (!push_hs_s || level !== 8'd1) begin
         n_fail++; $display("FAIL single_push: got hs=%b level=%0d expected hs=1 level=1", push_hs_s, level);
      end
      first_valid = 0;
      for (int k = 1; k <= 10 && first_valid == 0; k++) begin
         tick();
         if (pop_valid === 1'b1) begin
            first_valid = k;
            n_checks++;
            if (pop_data !== 8'hA5) begin
               n_fail++; $display("FAIL single_data: got %h expected a5", pop_data);
            end
         end
      end
      n_checks++;
      if (first_valid != 4) begin
         n_fail++; $display("FAIL single_latency: got %0d edges expected 4", first_valid);
      end
      tick();
      n_checks++;
      if (level !== 8'd0 || pop_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_after_pop: got level=%0d pop_valid=%b expected 0 0", level, pop_valid);
      end
      pop_ready = 1'b0;
   endtask

   task automatic test_fill_drain();
      int expv;
      do_reset();
      pop_ready = 1'b0;
      for (int i = 0; i < 128; i++) push_byte(8'(i));
      push_valid = 1'b1;
      push_data  = 8'h80;
      for (int k = 0; k < 4; k++) tick();
      n_checks++;
      if (full !== 1'b1 || level !== 8'd128 || push_ready !== 1'b0) begin
         n_fail++; $display("FAIL full_stall: got full=%b level=%0d push_ready=%b expected 1 128 0",
                            full, level, push_ready);
      end
      push_valid = 1'b0;
      pop_ready  = 1'b1;
      expv = 0;
      for (int k = 0; k < 2000 && q.size() > 0; k++) begin
         tick();
         if (pop_hs_s) expv++;
      end
      n_checks++;
      if (expv != 128 || empty !== 1'b1) begin
         n_fail++; $display("FAIL drain_count: got %0d pops empty=%b expected 128 pops empty=1", expv, empty);
      end
      pop_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int pushed, popped;
      do_reset();
      wr_cycles  = 0;
      rd_cycles  = 0;
      pushed     = 0;
      popped     = 0;
      pop_ready  = 1'b1;
      for (int k = 0; k < 6000 && pushed < 300; k++) begin
         push_valid = 1'b1;
         push_data  = 8'(pushed);
         tick();
         if (pop_hs_s) popped++;
         if (push_hs_s) pushed++;
      end
      push_valid = 1'b0;
      for (int k = 0; k < 2000 && q.size() > 0; k++) begin
         tick();
         if (pop_hs_s) popped++;
      end
      n_checks++;
      if (pushed != 300 || popped != 300) begin
         n_fail++; $display("FAIL stream_count: got pushed=%0d popped=%0d expected 300 300", pushed, popped);
      end
      n_checks++;
      if (wr_cycles != 300 || rd_cycles != 300) begin
         n_fail++; $display("FAIL stream_ops: got wr=%0d rd=%0d expected 300 300", wr_cycles, rd_cycles);
      end
      pop_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      pop_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
      for (int k = 0; k < 30 && pop_valid !== 1'b1; k++) tick();
      pop_ready  = 1'b1;
      push_valid = 1'b1;
      push_data  = 8'h77;
      tick();
      pop_ready  = 1'b0;
      push_valid = 1'b0;
      for (int k = 0; k < 5 && rd_enable !== 1'b1; k++) tick();
      n_checks++;
      if (rd_enable !== 1'b1 || level !== 8'd5) begin
         n_fail++; $display("FAIL mid_setup: got rd=%b level=%0d expected rd=1 level=5", rd_enable, level);
      end
      sram_ares = 1'b1;
      tick();
      sram_ares = 1'b0;
      n_checks++;
      if (level !== 8'd0 || wr_enable !== 1'b0 || rd_enable !== 1'b0 || pop_valid !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset: got level=%0d wr=%b rd=%b pop_valid=%b expected all 0",
                            level, wr_enable, rd_enable, pop_valid);
      end
      push_byte(8'h3C);
      for (int k = 0; k < 10 && pop_valid !== 1'b1; k++) tick();
      n_checks++;
      if (pop_valid !== 1'b1 || pop_data !== 8'h3C) begin
         n_fail++; $display("FAIL mid_after: got valid=%b data=%h expected 1 3c", pop_valid, pop_data);
      end
      drain();
   endtask

   task automatic test_backpressure();
      do_reset();
      pop_ready = 1'b0;
      push_byte(8'h11);
      push_byte(8'h22);
      for (int k = 0; k < 20 && pop_valid !== 1'b1; k++) tick();
      for (int k = 0; k < 10; k++) begin
         tick();
         n_checks++;
         if (pop_valid !== 1'b1 || pop_data !== 8'h11 || rd_enable !== 1'b0) begin
            n_fail++; $display("FAIL backpressure: got valid=%b data=%h rd=%b expected 1 11 0",
                               pop_valid, pop_data, rd_enable);
         end
      end
      drain();
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         push_valid = 1'($urandom_range(0, 1));
         push_data  = 8'($urandom);
         pop_ready  = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drain();
      test_back_to_back();
      test_reset_mid();
      test_backpressure();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_byte_sram_fifo_ctrl
`default_nettype wire
